risc_fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the risc_kgp decode/execute datapath.
- Owns the fetch PC and issues word reads to the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned instructions in a small prefetch FIFO and presents them to the core with a valid/ready handshake.
- Accepts branch/jump redirects from the branching logic, flushing the FIFO and any in-flight read.

---
 rtl/risc_kgp_pkg.sv | 25 ++
 rtl/risc_fetch_unit_if.sv | 26 ++
 rtl/risc_fetch_fifo.sv | 69 ++++++
 rtl/risc_fetch_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/risc_kgp_pkg.sv
// Shared types and widths for the risc_kgp fetch front end.
package risc_kgp_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Saturating 32-bit add used by the optional performance counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/risc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// valid/ready instruction stream toward decode.
interface risc_fetch_unit_if;
  import risc_kgp_pkg::*;

  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_en, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/risc_fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; clear dominates push/pop.
module risc_fetch_fifo
  import risc_kgp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch stage: PC owner, credit-based imem requests, prefetch FIFO
// and redirect flush. Define RISC_FETCH_PERF_EN to add perf_fetched/perf_flushed.
module risc_fetch_unit
  import risc_kgp_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  risc_fetch_unit_if.master  bus
`ifdef RISC_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occupancy_c;
  logic [CNT_W-1:0]  count_next_c;
  fetch_entry_t      head;
  fetch_entry_t      push_entry_c;
  logic              head_valid_c;
  logic              issue_c;
  logic              push_c;
  logic              pop_c;
  logic              redirect_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect with a response in the air goes through FLUSH;
  // otherwise park in HOLD whenever the next cycle would have no credit.
  always_comb begin
    state_d = state_q;
    if (redirect_c) begin
      state_d = inflight_q ? FLUSH : RUN;
    end else if (32'(count_next_c) + 32'(issue_c) >= DEPTH) begin
      state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  // Issue/push/pop control and datapath next values.
  always_comb begin
    redirect_c   = bus.redirect_valid;
    head_valid_c = (count != '0);
    occupancy_c  = count + CNT_W'(inflight_q);
    issue_c      = reset && !redirect_c && (state_q != HOLD) &&
                   (occupancy_c < CNT_W'(DEPTH));
    push_c       = inflight_q && (state_q != FLUSH) && !redirect_c;
    pop_c        = head_valid_c && bus.instr_ready && !redirect_c;
    push_entry_c = '{instr: bus.imem_rdata, pc: tag_pc_q};

    if (redirect_c) begin
      count_next_c = '0;
    end else begin
      count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue_c;
    if (redirect_c) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue_c) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      tag_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
    end
  end

  risc_fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_c),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .count     (count),
    .head      (head)
  );

  // imem_en must be same-cycle with the credit check to meet 1-cycle memory latency.
  assign bus.imem_en     = issue_c;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = head_valid_c;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

`ifdef RISC_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [31:0] dropped_c;

  // Dropped work: FIFO contents on redirect plus any response that won't be pushed.
  always_comb begin
    dropped_c = '0;
    if (redirect_c || (state_q == FLUSH)) begin
      dropped_c = 32'(inflight_q) + (redirect_c ? 32'(count) : 32'd0);
    end
    perf_fetched_d = sat_add32(perf_fetched_q, 32'(push_c));
    perf_flushed_d = sat_add32(perf_flushed_q, dropped_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
